// File: rtl/axi_stream_if.sv
// axi_stream_if: minimal AXI-Stream channel used to carry the serial
// configuration bitstream into the fabric logic elements.
interface axi_stream_if #(
   parameter int unsigned DATA_W = 1
);
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic [DATA_W-1:0] tdata;

   modport master (
      output tvalid,
      output tdata,
      output tlast,
      input  tready
   );

   modport slave (
      input  tvalid,
      input  tdata,
      input  tlast,
      output tready
   );
endinterface

// File: rtl/lut_array.sv
// lut_array: bank of NUM_OUTPUTS independent WIDTH-input LUTs sharing one input
// vector, loaded serially (one bit per beat) over an AXI-Stream slave port.
// Each LUT has a mode bit selecting combinational or registered output.
// Optional build macro: LUT_ARRAY_TLAST_CHECK_EN enables tlast framing checks
// (mis-framed stream -> ERROR state, cfg_error high).
module lut_array #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned NUM_OUTPUTS = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cfg,
   axi_stream_if.slave            cfg_bitstream,
   output logic                   cfg_ready,
   output logic                   cfg_error,
   input  logic                   run,
   input  logic [WIDTH-1:0]       run_in,
   output logic [NUM_OUTPUTS-1:0] run_out
);

   localparam int unsigned DEPTH    = 1 << WIDTH;
   localparam int unsigned SLICE    = DEPTH + 1;
   localparam int unsigned CFG_BITS = NUM_OUTPUTS * SLICE;
   localparam int unsigned CNT_W    = $clog2(CFG_BITS);

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_LOAD  = 3'd1,
      S_IDLE  = 3'd2,
      S_RUN   = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CFG_BITS-1:0]    cfg_q;
   logic [NUM_OUTPUTS-1:0] ff_q;
   logic [NUM_OUTPUTS-1:0] lut_val;
   logic [NUM_OUTPUTS-1:0] mode;
   logic                   tready_q;
   logic                   cfg_ready_q;
   logic                   beat;
   logic                   last_beat;
   logic                   tlast_bad;
   logic                   load_entry;

   // Per-LUT view of the flat config vector: DEPTH table bits then the mode bit.
   for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_lut
      logic [DEPTH-1:0] tt;
      assign tt         = cfg_q[k*SLICE +: DEPTH];
      assign mode[k]    = cfg_q[k*SLICE + DEPTH];
      assign lut_val[k] = tt[run_in];
   end

   assign beat      = cfg_bitstream.tvalid && tready_q;
   assign last_beat = (cnt_q == CNT_W'(CFG_BITS - 1));

`ifdef LUT_ARRAY_TLAST_CHECK_EN
   logic cfg_error_q;
   assign tlast_bad = beat && (cfg_bitstream.tlast != last_beat);
   assign cfg_error = cfg_error_q;
`else
   assign tlast_bad = 1'b0;
   assign cfg_error = 1'b0;
`endif

   // Next-state decode; run has priority over cfg outside LOAD.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_INIT:  if (cfg) state_d = S_LOAD;
         S_LOAD: begin
            if (tlast_bad)              state_d = S_ERROR;
            else if (beat && last_beat) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (run)      state_d = S_RUN;
            else if (cfg) state_d = S_LOAD;
         end
         S_RUN:   if (!run) state_d = cfg ? S_LOAD : S_IDLE;
         S_ERROR: if (cfg)  state_d = S_LOAD;
         default: state_d = S_INIT;
      endcase
      load_entry = (state_d == S_LOAD) && (state_q != S_LOAD);
   end

   // State, registered status outputs, config storage, beat counter and output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_INIT;
         cnt_q       <= '0;
         cfg_q       <= '0;
         ff_q        <= '0;
         tready_q    <= 1'b0;
         cfg_ready_q <= 1'b0;
`ifdef LUT_ARRAY_TLAST_CHECK_EN
         cfg_error_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         tready_q    <= (state_d == S_LOAD);
         cfg_ready_q <= (state_d == S_IDLE) || (state_d == S_RUN);
`ifdef LUT_ARRAY_TLAST_CHECK_EN
         cfg_error_q <= (state_d == S_ERROR);
`endif
         if (load_entry)
            cnt_q <= '0;
         else if (beat)
            cnt_q <= last_beat ? '0 : cnt_q + CNT_W'(1);
         if (beat)
            cfg_q[cnt_q] <= cfg_bitstream.tdata[0];
         if (load_entry)
            ff_q <= '0;
         else if (state_q == S_RUN)
            ff_q <= lut_val;
      end
   end

   assign cfg_bitstream.tready = tready_q;
   assign cfg_ready            = cfg_ready_q;

   // Outputs are forced low outside RUN; mode selects flop or direct table value.
   assign run_out = (state_q == S_RUN) ? ((mode & ff_q) | (~mode & lut_val))
                                       : '0;

endmodule

// File: tb/tb_lut_array.sv
// tb_lut_array: directed test of lut_array with WIDTH=2, NUM_OUTPUTS=2.
module tb_lut_array;

   localparam logic [9:0] VEC_A = 10'b1_0110_0_1000; // AND comb, XOR registered
   localparam logic [9:0] VEC_B = 10'b0_0111_1_1110; // OR registered, NAND comb

   logic       clk;
   logic       rst_n;
   logic       cfg;
   logic       run;
   logic [1:0] run_in;
   logic [1:0] run_out;
   logic       cfg_ready;
   logic       cfg_error;

   int n_total = 0;
   int n_bad   = 0;

   axi_stream_if #(.DATA_W(1)) cfg_if ();

   lut_array #(.WIDTH(2), .NUM_OUTPUTS(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg           (cfg),
      .cfg_bitstream (cfg_if),
      .cfg_ready     (cfg_ready),
      .cfg_error     (cfg_error),
      .run           (run),
      .run_in        (run_in),
      .run_out       (run_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic start_load();
      cfg = 1'b1;
      tick();
      cfg = 1'b0;
   endtask

   task automatic send_beat(input logic b, input logic l, input bit gap);
      int n;
      if (gap) begin
         cfg_if.tvalid = 1'b0;
         tick();
      end
      cfg_if.tvalid   = 1'b1;
      cfg_if.tdata[0] = b;
      cfg_if.tlast    = l;
      n = 0;
      while (!cfg_if.tready && n < 20) begin
         tick();
         n++;
      end
      if (!cfg_if.tready) check_val("beat_timeout", 32'(cfg_if.tready), 32'd1);
      tick();
      cfg_if.tvalid = 1'b0;
      cfg_if.tlast  = 1'b0;
   endtask

   task automatic load_vec(input logic [9:0] v, input bit gap, input int first,
                           input int last_i, input int tlast_at);
      for (int i = first; i <= last_i; i++)
         send_beat(v[i], logic'(i == tlast_at), gap);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; cfg = 1'b0; run = 1'b0; run_in = 2'b00;
      cfg_if.tvalid = 1'b0; cfg_if.tdata = '0; cfg_if.tlast = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_cfg_ready", 32'(cfg_ready), 0);
      check_val("rst_tready", 32'(cfg_if.tready), 0);
      check_val("rst_cfg_error", 32'(cfg_error), 0);
      check_val("rst_run_out", 32'(run_out), 0);
      rst_n = 1'b1;
      run = 1'b1; run_in = 2'b11;
      tick();
      check_val("init_ignores_run", 32'(run_out), 0);
      run = 1'b0;

      // First load: AND (comb) + XOR (registered)
      start_load();
      check_val("load_tready", 32'(cfg_if.tready), 1);
      check_val("load_cfg_ready", 32'(cfg_ready), 0);
      load_vec(VEC_A, 1'b0, 0, 9, 9);
      check_val("loaded_cfg_ready", 32'(cfg_ready), 1);
      check_val("loaded_tready", 32'(cfg_if.tready), 0);
      check_val("loaded_run_out", 32'(run_out), 0);

      run = 1'b1; run_in = 2'b11;
      tick(); settle();
      check_val("run_11_first", 32'(run_out), 32'b01);
      tick();
      run_in = 2'b01; settle();
      check_val("run_01_same", 32'(run_out), 32'b00);
      tick(); settle();
      check_val("run_01_next", 32'(run_out), 32'b10);
      run_in = 2'b00; settle();
      check_val("run_00_same", 32'(run_out), 32'b10);
      tick(); settle();
      check_val("run_00_next", 32'(run_out), 32'b00);

      run = 1'b0; run_in = 2'b11;
      tick(); settle();
      check_val("idle_run_out", 32'(run_out), 0);
      check_val("idle_tready", 32'(cfg_if.tready), 0);
      check_val("idle_cfg_ready", 32'(cfg_ready), 1);

      // Reconfigure from RUN with a stalled stream
      run = 1'b1;
      tick();
      tick();
      cfg = 1'b1;
      tick(); settle();
      check_val("run_cfg_stays_tready", 32'(cfg_if.tready), 0);
      check_val("run_cfg_stays_ready", 32'(cfg_ready), 1);
      check_val("run_cfg_stays_out", 32'(run_out), 32'b01);
      run = 1'b0;
      tick();
      cfg = 1'b0;
      check_val("reload_tready", 32'(cfg_if.tready), 1);
      check_val("reload_cfg_ready", 32'(cfg_ready), 0);
      check_val("reload_run_out", 32'(run_out), 0);
      load_vec(VEC_B, 1'b1, 0, 8, 9);
      check_val("stall_9_ready", 32'(cfg_ready), 0);
      check_val("stall_9_tready", 32'(cfg_if.tready), 1);
      load_vec(VEC_B, 1'b1, 9, 9, 9);
      check_val("stall_done_ready", 32'(cfg_ready), 1);

      run = 1'b1; run_in = 2'b00;
      tick(); settle();
      check_val("b_run_00_first", 32'(run_out), 32'b10);
      tick();
      run_in = 2'b10; settle();
      check_val("b_run_10_same", 32'(run_out), 32'b10);
      tick();
      run_in = 2'b11; settle();
      check_val("b_run_11", 32'(run_out), 32'b01);

      // Async reset in the middle of a load
      run = 1'b0; cfg = 1'b1;
      tick();
      cfg = 1'b0;
      load_vec(VEC_A, 1'b0, 0, 4, 9);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_tready", 32'(cfg_if.tready), 0);
      check_val("mid_rst_cfg_ready", 32'(cfg_ready), 0);
      check_val("mid_rst_run_out", 32'(run_out), 0);
      tick();
      rst_n = 1'b1;
      tick();
      start_load();
      load_vec(VEC_A, 1'b0, 0, 9, 9);
      check_val("post_rst_ready", 32'(cfg_ready), 1);
      run = 1'b1; run_in = 2'b11;
      tick(); settle();
      check_val("post_rst_run_11", 32'(run_out), 32'b01);
      tick();
      run_in = 2'b10; settle();
      check_val("post_rst_run_10", 32'(run_out), 32'b00);
      tick(); settle();
      check_val("post_rst_run_10_next", 32'(run_out), 32'b10);

      // Early tlast on the fourth beat
      run = 1'b0;
      tick();
      start_load();
      load_vec(VEC_B, 1'b0, 0, 3, 3);
`ifdef LUT_ARRAY_TLAST_CHECK_EN
      check_val("tlast_err", 32'(cfg_error), 1);
      check_val("tlast_err_tready", 32'(cfg_if.tready), 0);
      check_val("tlast_err_ready", 32'(cfg_ready), 0);
      start_load();
      check_val("err_reload_tready", 32'(cfg_if.tready), 1);
      check_val("err_reload_error", 32'(cfg_error), 0);
      load_vec(VEC_B, 1'b0, 0, 9, 9);
`else
      check_val("tlast_ignored_error", 32'(cfg_error), 0);
      check_val("tlast_ignored_tready", 32'(cfg_if.tready), 1);
      load_vec(VEC_B, 1'b0, 4, 9, 9);
`endif
      check_val("tlast_final_error", 32'(cfg_error), 0);
      check_val("tlast_final_ready", 32'(cfg_ready), 1);
      run = 1'b1; run_in = 2'b01;
      tick(); settle();
      check_val("tlast_run_first", 32'(run_out), 32'b10);
      tick(); settle();
      check_val("tlast_run_next", 32'(run_out), 32'b11);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/lut_array.md
# lut_array

Parametrised bank of `NUM_OUTPUTS` independent `WIDTH`-input look-up tables sharing one input vector, one configuration stream and one run/config control pair. Each output carries its own truth table and a per-output mode bit that selects a combinational output or a registered (flip-flop) output. This is the configurable logic element of the tiny-FPGA fabric, fed serially from the bitstream distributor and replacing the single-output LUT.

## Interface
- `WIDTH`, 4, LUT input count; truth-table depth per output is `DEPTH = 1 << WIDTH` (localparam).
- `NUM_OUTPUTS`, 2, number of LUTs/outputs; `CFG_BITS = NUM_OUTPUTS*(DEPTH+1)` (localparam).
- `clk`  in  1  clock; everything is on the rising edge.
- `rst_n`  in  1  reset: one clock; reset is asynchronous and active-low.
- `cfg`  in  1  request (re)configuration; level, sampled per state rules.
- `cfg_bitstream`  axi_stream_if.slave  —  uses `tvalid`, `tready` (driven), `tdata[0]` (one config bit per beat), `tlast`.
- `cfg_ready`  out  1  high while a valid configuration is held (IDLE, RUN).
- `cfg_error`  out  1  high in ERROR; tied 0 when the check is compiled out.
- `run`  in  1  evaluate.
- `run_in`  in  WIDTH  shared LUT input vector.
- `run_out`  out  NUM_OUTPUTS  LUT outputs, bit k = LUT k.

## Operation
- States: INIT, LOAD, IDLE, RUN, ERROR. Reset → INIT; all outputs 0, truth tables and mode bits 0, registers 0, beat counter 0.
- INIT: `cfg`=1 → LOAD, else stay.
- LOAD: `tready`=1 (only state where it is). Each handshake (`tvalid&&tready`) writes `tdata[0]` to config bit index = beat counter, counter +1. Bit order: for k=0..NUM_OUTPUTS-1: `DEPTH` truth-table bits of LUT k, index 0 first, then mode bit of LUT k (0 = combinational, 1 = registered). Handshake on index `CFG_BITS-1` → IDLE, counter cleared. `cfg`/`run` ignored in LOAD.
- On entry to LOAD: counter cleared, output flops cleared; table contents overwritten progressively.
- IDLE: `run`=1 → RUN; else `cfg`=1 → LOAD; else stay (run has priority).
- RUN: `run`=1 stays; `run`=0 and `cfg`=1 → LOAD; otherwise → IDLE.
- `run_out[k]` in RUN: mode 0 → `table_k[run_in]` combinationally; mode 1 → output flop k. Outside RUN all `run_out` bits are 0 (never X).
- Output flop k loads `table_k[run_in]` on each edge where state is RUN; holds otherwise.
- ERROR: `tready`=0, `cfg_ready`=0, `cfg_error`=1; `cfg`=1 → LOAD, else stay.
- Reset asserted mid-LOAD or mid-RUN: immediate return to INIT with reset values; partial configuration discarded.

## Timing
- State and all outputs other than combinational `run_out` are registered or decoded from registered state.
- `cfg` sampled at edge N in INIT/IDLE → `tready`=1 from cycle N+1.
- Final beat accepted at edge M → `tready`=0, `cfg_ready`=1 from cycle M+1.
- `run` sampled at edge R in IDLE → RUN from R+1; combinational outputs valid in the same cycle as `run_in`; registered outputs reflect `run_in` of cycle C at cycle C+1 (first RUN cycle shows flop value, 0 after a load).
- Throughput: one config bit per cycle when `tvalid` stays high; `tvalid` gaps simply stall the counter.

## Configuration
- `LUT_ARRAY_TLAST_CHECK_EN` defined: in LOAD, `tlast`=1 on any beat other than index `CFG_BITS-1`, or `tlast`=0 on that beat, → ERROR at next edge (the offending beat is consumed); `cfg_ready` stays 0 until a clean reload.
- Not defined: `tlast` ignored entirely; ERROR unreachable; `cfg_error` constant 0.

## Test plan
- Reset then WIDTH=2, NUM_OUTPUTS=2: load bits {tt0=0b1000 (AND), mode0=0, tt1=0b0110 (XOR), mode1=1}, tlast on 10th beat → `cfg_ready`=1 cycle after beat 10; run=1, run_in=2'b11 → run_out[0]=1 same cycle, run_out[1]=0 next cycle; run_in=2'b01 → run_out[0]=0, run_out[1]=1 one cycle later.
- Outputs outside RUN: after load, run=0 → run_out=2'b00, `tready`=0.
- Stalled stream: tvalid toggling every other cycle over a full load → load completes after exactly CFG_BITS handshakes, table correct.
- Reconfig from RUN: run=1 and cfg=1 → stays RUN; run=0,cfg=1 → LOAD, cfg_ready=0, output flops 0, new table takes effect after reload.
- Async reset asserted mid-LOAD (beat 5) → INIT immediately, cfg_ready=0, tready=0; fresh load succeeds from index 0.
- With `LUT_ARRAY_TLAST_CHECK_EN`: tlast on beat 4 → cfg_error=1, tready=0; cfg=1 → LOAD, clean stream → cfg_error=0, cfg_ready=1. Without macro: same stimulus ignored, load completes normally.
